// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: packs little-endian bytes into 32-bit words,
// writes them sequentially into instruction memory and holds the CPU in reset while busy.
module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] load_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst_n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [23:0]      buffer;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] next_idx;

  assign next_idx  = word_idx + ONE;
  assign cpu_rst_n = rst_n & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      buffer        <= '0;
      word_idx      <= '0;
      target        <= '0;
      byte_ready    <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            words_written <= '0;
            word_idx      <= '0;
            byte_cnt      <= '0;
            error         <= (load_words > DEPTH_CNT);
            // Oversized and empty loads finish immediately without touching memory.
            if ((load_words > DEPTH_CNT) || (load_words == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= LOAD;
              target     <= load_words;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (byte_valid) begin
            if (byte_cnt == 2'd3) begin
              imem_wdata <= {byte_data, buffer};
              imem_addr  <= BASE_ADDR + 32'({word_idx, 2'b00});
              imem_we    <= 1'b1;
              byte_ready <= 1'b0;
              byte_cnt   <= '0;
              state      <= WRITE;
            end else begin
              buffer[8*byte_cnt +: 8] <= byte_data;
              byte_cnt                <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          words_written <= words_written + ONE;
          word_idx      <= next_idx;
          if (next_idx == target) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= LOAD;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load scenarios plus reset and abort sequences.
module tb_imem_loader;

  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] load_words;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             cpu_rst_n;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_written;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int low_cnt = 0;
  bit counting = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] mem [256];

  typedef struct {
    logic [CNT_W-1:0] load_words;
    int               gap;
    logic             exp_error;
    int               exp_writes;
    int               exp_low;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] stream_bytes [8];
  logic [31:0] exp_words [2];

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_words(load_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Memory model and write log, sampled with the pre-edge strobe value.
  always @(posedge clk) begin
    cyc++;
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
      mem[imem_addr[9:2]] = imem_wdata;
    end
  end

  always @(negedge clk) begin
    if (counting && !cpu_rst_n) low_cnt++;
    if (imem_we) checkOutput("byte_ready_in_write", 32'(byte_ready), 32'd0);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!byte_ready) begin
      checkOutput("byte_ready_timeout", 32'd0, 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int n = 0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    low_cnt    = 0;
    start      = 1'b1;
    load_words = v.load_words;
    @(posedge clk); #1;
    start      = 1'b0;
    load_words = '0;
    counting   = 1'b1;
    checkOutput("busy_after_start", 32'(busy), 32'(v.exp_writes > 0));
    checkOutput("done_after_start", 32'(done), 32'(v.exp_writes == 0));
    for (int i = 0; i < v.exp_writes * 4; i++) sendByte(stream_bytes[i], v.gap);
    byte_valid = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    counting = 1'b0;
    checkOutput("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic checkScenario(input vec_t v);
    checkOutput("error", 32'(error), 32'(v.exp_error));
    checkOutput("words_written", 32'(words_written), 32'(v.exp_writes));
    checkOutput("write_count", 32'(wr_addr.size()), 32'(v.exp_writes));
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    for (int i = 0; i < v.exp_writes && i < wr_addr.size(); i++) begin
      checkOutput("write_addr", wr_addr[i], 32'(4 * i));
      checkOutput("write_data", wr_data[i], exp_words[i]);
    end
    if (v.gap == 0 && wr_cyc.size() == 2) checkOutput("write_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
    if (v.exp_low >= 0) checkOutput("cpu_rst_low_cycles", 32'(low_cnt), 32'(v.exp_low));
  endtask

  initial begin
    stream_bytes = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    exp_words    = '{32'h0050_0513, 32'h00A0_0593};
    vecs[0] = '{9'd2,   0, 1'b0, 2, 10};
    vecs[1] = '{9'd2,   3, 1'b0, 2, -1};
    vecs[2] = '{9'd0,   0, 1'b0, 0, 0};
    vecs[3] = '{9'd300, 0, 1'b1, 0, 0};
    vecs[4] = '{9'd1,   0, 1'b0, 1, 5};
    foreach (mem[i]) mem[i] = '0;

    rst_n = 1'b0; start = 1'b0; load_words = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("reset_words_written", 32'(words_written), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    checkOutput("idle_byte_ready", 32'(byte_ready), 32'd0);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] scenario %0d load_words=%0d gap=%0d", i, vecs[i].load_words, vecs[i].gap);
      applyStimulus(vecs[i]);
      checkScenario(vecs[i]);
    end

    // Asynchronous reset in the middle of a cycle while outputs are non-zero.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_outputs",
                {byte_ready, imem_we, busy, done, error, cpu_rst_n}, 32'd0);
    checkOutput("async_rst_addr", imem_addr, 32'd0);
    checkOutput("async_rst_wdata", imem_wdata, 32'd0);
    checkOutput("async_rst_words", 32'(words_written), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    checkOutput("post_rst_idle", {busy, done}, 32'd0);

    // Start ignored while loading, then reset abort partway through word 1.
    @(posedge clk); #1;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    foreach (mem[i]) mem[i] = '0;
    start = 1'b1; load_words = 9'd2;
    @(posedge clk); #1;
    start = 1'b0; load_words = '0;
    sendByte(8'h13, 0);
    start = 1'b1; load_words = 9'd1;
    sendByte(8'h05, 0);
    start = 1'b0; load_words = '0;
    sendByte(8'h50, 0);
    sendByte(8'h00, 0);
    sendByte(8'h93, 0);
    sendByte(8'h05, 0);
    byte_valid = 1'b0;
    checkOutput("abort_pre_writes", 32'(wr_addr.size()), 32'd1);
    checkOutput("abort_pre_busy_done", {busy, done}, 32'b10);
    checkOutput("abort_pre_words", 32'(words_written), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_words", 32'(words_written), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_writes", 32'(wr_addr.size()), 32'd1);
    checkOutput("abort_mem0", mem[0], 32'h0050_0513);
    checkOutput("abort_idle", {busy, done, cpu_rst_n}, 32'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the CPU's instruction-memory read path.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver or test harness.
- Assembles the bytes into little-endian 32-bit instruction words and writes them sequentially into the instruction memory write port.
- Holds the CPU core in reset while a program load is in progress.

Parameters:
- DEPTH, 256: instruction memory size in 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be 4-byte aligned.
- CNT_W, $clog2(DEPTH)+1: width of the word-count fields. Derived; do not override.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load; sampled only in IDLE and DONE.
- load_words  in  CNT_W  number of words to load; sampled on the cycle start is accepted.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  32  byte address of the write; BASE_ADDR + 4*word_idx.
- imem_wdata  out  32  assembled instruction word.
- cpu_rst_n  out  1  active-low reset to the CPU core.
- busy  out  1  high in LOAD and WRITE.
- done  out  1  high in DONE.
- error  out  1  load_words exceeded DEPTH on the last start; cleared by the next accepted start.
- words_written  out  CNT_W  words committed since the last accepted start.

Behaviour:
- States: IDLE, LOAD, WRITE, DONE.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; byte_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; busy=0; done=0; error=0; words_written=0.
  - Byte counter, word_idx and assembly buffer are cleared.
- cpu_rst_n = rst_n AND NOT busy. It is combinational, so the CPU is in reset during chip reset and during a load.
- IDLE/DONE with start=1, next cycle:
  - load_words > DEPTH: error=1, state=DONE, no writes.
  - load_words == 0: error=0, state=DONE, no writes.
  - otherwise: error=0, words_written=0, word_idx=0, byte counter=0, state=LOAD. load_words is latched into target.
- LOAD:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready at the rising edge.
  - Byte k (k=0..3) of a word goes into buffer bits [8k+7:8k] (little-endian).
  - When the 4th byte is accepted: next cycle state=WRITE, imem_wdata=buffer (including the 4th byte), imem_addr=BASE_ADDR+4*word_idx.
  - byte_valid low simply stalls; there is no timeout.
- WRITE (exactly one cycle):
  - imem_we=1 and byte_ready=0. The stream must hold any pending byte.
  - Next cycle: words_written+1 and word_idx+1. If word_idx+1 == target, state=DONE; else state=LOAD with byte counter=0.
- imem_addr and imem_wdata hold their last values outside WRITE. imem_we is high only in WRITE.
- DONE: done=1 and byte_ready=0. Bytes presented here are not consumed. A new start restarts the load.
- start while busy is ignored. load_words is ignored except on the start cycle.
- Minimum load time: 5 cycles per word (4 bytes in LOAD plus 1 WRITE) when byte_valid is held high.
- Reset mid-load: immediate return to IDLE. The partial word is discarded; words already written stay in memory. words_written=0.
- Address wrap: not possible; target ≤ DEPTH, so the last address is BASE_ADDR+4*(DEPTH-1).

Test Plan:
- Reset: assert rst_n=0 mid-simulation -> all outputs 0 in the same cycle, including cpu_rst_n=0; state IDLE after release, with cpu_rst_n=1.
- Two-word load: start with load_words=2, stream 13 05 50 00 93 05 A0 00 with byte_valid held high -> writes 0x00500513 at 0x0, then 0x00A00593 at 0x4. Exactly 2 imem_we pulses, 5 cycles apart. done=1, words_written=2, cpu_rst_n low only while busy.
- Backpressure: the same stream with byte_valid deasserted for 3 cycles between every byte -> identical writes and data. During the WRITE cycle, byte_ready=0 and the pending byte is not consumed.
- Zero length: start with load_words=0 -> DONE next cycle, no imem_we, error=0, cpu_rst_n never drops.
- Overflow: DEPTH=256, start with load_words=300 -> DONE next cycle, error=1, no writes. A later start with load_words=1 clears error.
- Start ignored, then reset abort: assert start again while in LOAD -> no effect. Pulse rst_n low after 2 bytes of word 1 (word 0 already written) -> IDLE, words_written=0, no further imem_we, and word 0 remains in memory.
